// File: rtl/tt_mem_host.sv
// ---------------------------------------------------------------------------
// tt_mem_host
//   Initiator for the tt_um 256-bit DFF memory pin interface. Byte read/write
//   commands arrive on a valid/ready port and are driven onto the memory's
//   ui_in/uio_in pins. Read data is captured from uo_out and returned on a
//   valid/ready response port. Every output is registered.
//
// Parameters
//   ADDR_W    byte address width (32 bytes = 256 bits)
//   READ_LAT  cycles from address on pins to uo_out valid (must be >= 1)
//   CNT_W     width of the completed-transaction counter
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we, cmd_addr, cmd_wdata command fields (wdata ignored for reads)
//   rsp_valid/rsp_ready         read response handshake
//   rsp_rdata                   read data
//   mem_ui                      memory ui_in: [ADDR_W-1:0]=addr, [7]=write enable
//   mem_uio                     memory uio_in: write data
//   mem_uo                      memory uo_out: read data
//   busy                        high whenever the FSM is not IDLE
//   txn_count                   writes + delivered reads, wraps silently
// ---------------------------------------------------------------------------
module tt_mem_host #(
  parameter int ADDR_W   = 5,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_rdata,
  output logic [7:0]        mem_ui,
  output logic [7:0]        mem_uio,
  input  logic [7:0]        mem_uo,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count
);

  localparam int LAT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

  if (READ_LAT < 1) begin : g_bad_read_lat
    $error("tt_mem_host: READ_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_t;

  // _p0: next-state values computed from the current registers and inputs
  state_t             state_p0;
  logic [LAT_W-1:0]   lat_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic               we_p0;
  logic [7:0]         wdata_p0;
  logic               vld_p0;
  logic [7:0]         rdata_p0;
  logic [CNT_W-1:0]   txn_p0;

  // _p1: registered state, directly drives the outputs
  state_t             state_p1;
  logic [LAT_W-1:0]   lat_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic               we_p1;
  logic [7:0]         wdata_p1;
  logic               vld_p1;
  logic [7:0]         rdata_p1;
  logic [CNT_W-1:0]   txn_p1;
  logic               ready_p1;
  logic               busy_p1;

  always_comb begin
    state_p0 = state_p1;
    lat_p0   = lat_p1;
    addr_p0  = addr_p1;
    we_p0    = 1'b0;
    wdata_p0 = wdata_p1;
    vld_p0   = vld_p1;
    rdata_p0 = rdata_p1;
    txn_p0   = txn_p1;
    unique case (state_p1)
      IDLE: begin
        if (cmd_valid && ready_p1) begin
          addr_p0 = cmd_addr;
          if (cmd_we) begin
            wdata_p0 = cmd_wdata;
            we_p0    = 1'b1;
            state_p0 = WR;
          end else begin
            lat_p0   = LAT_W'(READ_LAT);
            state_p0 = RD;
          end
        end
      end
      WR: begin
        txn_p0   = txn_p1 + CNT_W'(1);
        state_p0 = IDLE;
      end
      RD: begin
        lat_p0 = lat_p1 - LAT_W'(1);
        if (lat_p1 == LAT_W'(1)) begin
          rdata_p0 = mem_uo;
          vld_p0   = 1'b1;
          state_p0 = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          vld_p0   = 1'b0;
          txn_p0   = txn_p1 + CNT_W'(1);
          state_p0 = IDLE;
        end
      end
      default: state_p0 = IDLE;
    endcase
  end

  // _p0 -> _p1 register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
      lat_p1   <= '0;
      addr_p1  <= '0;
      we_p1    <= 1'b0;
      wdata_p1 <= '0;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      txn_p1   <= '0;
      ready_p1 <= 1'b1;
      busy_p1  <= 1'b0;
    end else begin
      state_p1 <= state_p0;
      lat_p1   <= lat_p0;
      addr_p1  <= addr_p0;
      we_p1    <= we_p0;
      wdata_p1 <= wdata_p0;
      vld_p1   <= vld_p0;
      rdata_p1 <= rdata_p0;
      txn_p1   <= txn_p0;
      ready_p1 <= (state_p0 == IDLE);
      busy_p1  <= (state_p0 != IDLE);
    end
  end

  assign cmd_ready = ready_p1;
  assign busy      = busy_p1;
  assign rsp_valid = vld_p1;
  assign rsp_rdata = rdata_p1;
  assign txn_count = txn_p1;
  assign mem_ui    = {we_p1, {(7-ADDR_W){1'b0}}, addr_p1};
  assign mem_uio   = wdata_p1;

endmodule

// File: tb/tb_tt_mem_host.sv
// ---------------------------------------------------------------------------
// tb_tt_mem_host
//   Directed bench for tt_mem_host. Instance 0 uses READ_LAT=1, CNT_W=16;
//   instance 1 uses READ_LAT=3, CNT_W=4 so the counter wrap is reachable.
//   Each instance talks to its own behavioural DFF memory whose read path
//   has READ_LAT-1 register stages, so data is valid on the capture edge.
// ---------------------------------------------------------------------------
module tb_tt_mem_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic       cmd_we    [2];
  logic [4:0] cmd_addr  [2];
  logic [7:0] cmd_wdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_rdata [2];
  logic [7:0] mem_ui    [2];
  logic [7:0] mem_uio   [2];
  logic [7:0] mem_uo    [2];
  logic       busy      [2];
  logic [15:0] txn_a;
  logic [3:0]  txn_b;

  int n_chk = 0;
  int n_err = 0;
  int exp_txn [2];
  int run     [2];
  int max_run [2];

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  logic [7:0] b_s1, b_s2;

  always #5 clk = ~clk;

  tt_mem_host #(.ADDR_W(5), .READ_LAT(1), .CNT_W(16)) dut_lat1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_we(cmd_we[0]),
    .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .mem_ui(mem_ui[0]), .mem_uio(mem_uio[0]), .mem_uo(mem_uo[0]),
    .busy(busy[0]), .txn_count(txn_a)
  );

  tt_mem_host #(.ADDR_W(5), .READ_LAT(3), .CNT_W(4)) dut_lat3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_we(cmd_we[1]),
    .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .mem_ui(mem_ui[1]), .mem_uio(mem_uio[1]), .mem_uo(mem_uo[1]),
    .busy(busy[1]), .txn_count(txn_b)
  );

  // Memory models: write on the edge where ui[7] is high.
  always @(posedge clk) begin
    if (mem_ui[0][7]) mem_a[mem_ui[0][4:0]] <= mem_uio[0];
    if (mem_ui[1][7]) mem_b[mem_ui[1][4:0]] <= mem_uio[1];
    b_s1 <= mem_b[mem_ui[1][4:0]];
    b_s2 <= b_s1;
  end
  assign mem_uo[0] = mem_a[mem_ui[0][4:0]];
  assign mem_uo[1] = b_s2;

  // Longest write-enable run seen on each memory port.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_ui[i][7] === 1'b1) run[i] = run[i] + 1;
      else run[i] = 0;
      if (run[i] > max_run[i]) max_run[i] = run[i];
    end
  end

  function automatic logic [31:0] txn_of(int i);
    return (i == 0) ? {16'h0, txn_a} : {28'h0, txn_b};
  endfunction

  function automatic logic [31:0] txn_exp(int i);
    return (i == 0) ? (exp_txn[i] & 32'hFFFF) : (exp_txn[i] & 32'hF);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic rst_pulse(int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    exp_txn[0] = 0;
    exp_txn[1] = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(int i, logic we, logic [4:0] a, logic [7:0] d);
    int b = 0;
    cmd_valid[i] = 1'b1;
    cmd_we[i]    = we;
    cmd_addr[i]  = a;
    cmd_wdata[i] = d;
    while (cmd_ready[i] !== 1'b1 && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (b >= 20) chk("accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid[i] = 1'b0;
  endtask

  task automatic do_write(int i, logic [4:0] a, logic [7:0] d);
    issue(i, 1'b1, a, d);
    chk("wr_ui", mem_ui[i], {1'b1, 2'b00, a});
    chk("wr_uio", mem_uio[i], d);
    chk("wr_cmd_ready", cmd_ready[i], 0);
    chk("wr_busy", busy[i], 1);
    @(negedge clk);
    exp_txn[i]++;
    chk("wr_done_ui", mem_ui[i], {1'b0, 2'b00, a});
    chk("wr_done_ready", cmd_ready[i], 1);
    chk("wr_txn", txn_of(i), txn_exp(i));
  endtask

  task automatic do_read(int i, logic [4:0] a, logic [7:0] exp, int hold, int lat);
    int n;
    issue(i, 1'b0, a, 8'h00);
    n = 1;
    while (rsp_valid[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_latency", n, lat + 1);
    chk("rd_data", rsp_rdata[i], exp);
    chk("rd_ui", mem_ui[i], {3'b000, a});
    // Unrelated command offered while the response waits must be ignored.
    cmd_valid[i] = (hold > 0);
    cmd_we[i]    = 1'b1;
    cmd_addr[i]  = a + 5'd1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid[i], 1);
      chk("hold_data", rsp_rdata[i], exp);
      chk("hold_ready", cmd_ready[i], 0);
      chk("hold_busy", busy[i], 1);
    end
    cmd_valid[i] = 1'b0;
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    exp_txn[i]++;
    chk("rsp_done_valid", rsp_valid[i], 0);
    chk("rsp_done_ready", cmd_ready[i], 1);
    chk("rsp_done_busy", busy[i], 0);
    chk("rd_txn", txn_of(i), txn_exp(i));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_we[i] = 1'b0; cmd_addr[i] = '0;
      cmd_wdata[i] = '0; rsp_ready[i] = 1'b0;
      exp_txn[i] = 0; run[i] = 0; max_run[i] = 0;
    end
    for (int k = 0; k < 32; k++) begin
      mem_a[k] = 8'h00;
      mem_b[k] = 8'h00;
    end

    // 1. reset with a write command pending
    rst = 1'b1;
    cmd_valid[0] = 1'b1; cmd_we[0] = 1'b1; cmd_addr[0] = 5'd9; cmd_wdata[0] = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ui", mem_ui[0], 0);
      chk("rst_uio", mem_uio[0], 0);
      chk("rst_ready", cmd_ready[0], 1);
      chk("rst_rsp_valid", rsp_valid[0], 0);
    end
    rst = 1'b0;
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready[0], 1);
    chk("post_rst_busy", busy[0], 0);
    chk("post_rst_rdata", rsp_rdata[0], 0);
    chk("post_rst_txn", txn_a, 0);
    chk("post_rst_ui", mem_ui[0], 0);

    // 2. write 0xA5 to 3, read it back
    do_write(0, 5'd3, 8'hA5);
    do_read(0, 5'd3, 8'hA5, 0, 1);
    chk("s2_txn", txn_a, 2);

    // 3. fill all addresses, read back in reverse
    rst_pulse(1);
    for (int k = 0; k < 32; k++) do_write(0, 5'(k), 8'(k) ^ 8'h5A);
    for (int k = 31; k >= 0; k--) do_read(0, 5'(k), 8'(k) ^ 8'h5A, 0, 1);
    chk("s3_txn", txn_a, 64);

    // 4. response back-pressure for 10 cycles
    do_read(0, 5'd17, 8'h4B, 10, 1);

    // 5. reset during RD, then during RSP
    issue(0, 1'b0, 5'd5, 8'h00);
    chk("s5_in_rd_valid", rsp_valid[0], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_txn[0] = 0; exp_txn[1] = 0;
    chk("s5_rd_abort_valid", rsp_valid[0], 0);
    chk("s5_rd_abort_ready", cmd_ready[0], 1);
    chk("s5_rd_abort_txn", txn_a, 0);
    issue(0, 1'b0, 5'd5, 8'h00);
    @(negedge clk);
    chk("s5_in_rsp_valid", rsp_valid[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s5_rsp_abort_valid", rsp_valid[0], 0);
    chk("s5_rsp_abort_busy", busy[0], 0);
    @(negedge clk);
    chk("s5_no_late_valid", rsp_valid[0], 0);
    do_write(0, 5'd3, 8'hA5);
    do_read(0, 5'd3, 8'hA5, 0, 1);
    chk("s5_txn", txn_a, 2);

    // 6. READ_LAT=3, back-to-back reads, 4-bit counter wrap
    do_write(1, 5'd7, 8'h3C);
    do_write(1, 5'd8, 8'hC3);
    do_read(1, 5'd7, 8'h3C, 0, 3);
    do_read(1, 5'd8, 8'hC3, 2, 3);
    for (int k = 0; k < 11; k++) do_write(1, 5'(k + 16), 8'(k) + 8'h10);
    chk("s6_txn_top", txn_b, 15);
    do_write(1, 5'd31, 8'h77);
    chk("s6_txn_wrap", txn_b, 0);
    do_read(1, 5'd31, 8'h77, 0, 3);
    chk("s6_txn_after_wrap", txn_b, 1);

    chk("wr_pulse_max_lat1", max_run[0], 1);
    chk("wr_pulse_max_lat3", max_run[1], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
